// File: rtl/hiscore_arb.sv
// ---------------------------------------------------------------------------
// hiscore_arb
//
// Arbiter and sequencer for the small high-score NVRAM. The RAM is shared by
// the game CPU and the data_io upload/download channel. Normally the CPU owns
// the RAM. A data_io transfer on the high-score index takes the RAM over and
// stalls the CPU until the transfer ends. The block also tracks unsaved CPU
// writes. Once CPU writes have been quiet for QUIET cycles it raises a
// one-cycle save request.
//
// Ports
//   clk_sys         system clock
//   reset_n         synchronous, active-low reset
//   cpu_addr/din/we CPU access bus (one-cycle write strobe)
//   cpu_dout        CPU read data (the RAM's registered output)
//   cpu_hold        CPU stall while a transfer owns the RAM
//   ioctl_*         data_io transfer bus (index, address, strobe, data)
//   ioctl_din       upload byte returned to data_io (registered)
//   ram_addr/din/we RAM port driven by whichever side owns the RAM
//   ram_dout        RAM read data, one-cycle latency
//   dirty           CPU has written since the last completed save or load
//   save_req        one-cycle pulse asking the host to save
// ---------------------------------------------------------------------------
module hiscore_arb #(
    parameter int          AW    = 6,
    parameter int          DW    = 8,
    parameter logic [7:0]  IDX   = 8'hFF,
    parameter logic [23:0] QUIET = 24'd12_000_000
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_hold,
    input  logic          ioctl_download,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic [24:0]   ioctl_addr,
    input  logic          ioctl_wr,
    input  logic [7:0]    ioctl_dout,
    output logic [DW-1:0] ioctl_din,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic          dirty,
    output logic          save_req
);

    typedef enum logic [2:0] {
        ST_CPU,
        ST_HOLD,
        ST_LOAD,
        ST_SAVE,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;

    logic          dirty_q, dirty_d;
    logic          armed_q, armed_d;
    logic [23:0]   quietCnt_q, quietCnt_d;
    logic          saveReq_q, saveReq_d;
    logic          pendValid_q, pendValid_d;
    logic [AW-1:0] pendAddr_q, pendAddr_d;
    logic [7:0]    pendData_q, pendData_d;
    logic [DW-1:0] ioctlDin_q, ioctlDin_d;

    logic          sel;
    logic          dl;
    logic          ul;
    logic          inRange;
    logic          cpuWrAccept;

    // A transfer counts only on the high-score index. When both directions
    // are flagged, the download takes priority. Any address bit above the
    // RAM width marks the byte as out of range, so it cannot alias onto a
    // low address.
    assign sel         = (ioctl_index == IDX);
    assign dl          = ioctl_download & sel;
    assign ul          = ioctl_upload & sel;
    assign inRange     = (ioctl_addr[24:AW] == '0);
    assign cpuWrAccept = (state_q == ST_CPU) & cpu_we;

    assign cpu_hold  = (state_q == ST_HOLD) | (state_q == ST_LOAD) | (state_q == ST_SAVE);
    assign cpu_dout  = ram_dout;
    assign ioctl_din = ioctlDin_q;
    assign dirty     = dirty_q;
    assign save_req  = saveReq_q;

    // Ownership sequencing. HOLD lasts exactly one cycle so that a CPU strobe
    // already in flight can drain before the transfer side takes the RAM.
    // DONE is a single cleanup cycle before the CPU gets the RAM back.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_CPU:  if (dl || ul) state_d = ST_HOLD;
            ST_HOLD: begin
                if (dl)      state_d = ST_LOAD;
                else if (ul) state_d = ST_SAVE;
                else         state_d = ST_CPU;
            end
            ST_LOAD: if (!dl) state_d = ST_DONE;
            ST_SAVE: if (!ul) state_d = ST_DONE;
            ST_DONE: state_d = ST_CPU;
            default: state_d = ST_CPU;
        endcase
    end

    // RAM port multiplexer. The owner of the current state drives the RAM.
    // In the first LOAD cycle, a download strobe that arrived during HOLD is
    // replayed from the pending register. Writes are forced off while reset
    // is asserted, so an aborted load cannot store one more byte.
    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = 1'b0;
        unique case (state_q)
            ST_CPU: ram_we = cpu_we;
            ST_LOAD: begin
                if (pendValid_q) begin
                    ram_addr = pendAddr_q;
                    ram_din  = DW'(pendData_q);
                    ram_we   = 1'b1;
                end else begin
                    ram_addr = ioctl_addr[AW-1:0];
                    ram_din  = DW'(ioctl_dout);
                    ram_we   = ioctl_wr & inRange;
                end
            end
            ST_SAVE: ram_addr = ioctl_addr[AW-1:0];
            default: ram_we = 1'b0;
        endcase
        if (!reset_n) ram_we = 1'b0;
    end

    // Dirty tracking and the quiet-time countdown. An accepted CPU write
    // reloads and arms the counter. The counter only runs while the CPU owns
    // the RAM, so a transfer freezes it. It fires save_req once on reaching
    // zero and then disarms. A finished transfer clears dirty and disarms
    // the counter, because the host copy now matches the RAM. The same block
    // latches a HOLD-window download strobe and registers the upload byte.
    always_comb begin
        dirty_d     = dirty_q;
        armed_d     = armed_q;
        quietCnt_d  = quietCnt_q;
        saveReq_d   = 1'b0;
        pendValid_d = 1'b0;
        pendAddr_d  = pendAddr_q;
        pendData_d  = pendData_q;
        ioctlDin_d  = ioctlDin_q;

        if (state_q == ST_DONE) begin
            dirty_d    = 1'b0;
            armed_d    = 1'b0;
            quietCnt_d = '0;
        end else if (cpuWrAccept) begin
            dirty_d    = 1'b1;
            armed_d    = 1'b1;
            quietCnt_d = QUIET;
        end else if (armed_q && (state_q == ST_CPU)) begin
            if (quietCnt_q <= 24'd1) begin
                quietCnt_d = '0;
                armed_d    = 1'b0;
                saveReq_d  = 1'b1;
            end else begin
                quietCnt_d = quietCnt_q - 24'd1;
            end
        end

        if ((state_q == ST_HOLD) && dl && ioctl_wr && inRange) begin
            pendValid_d = 1'b1;
            pendAddr_d  = ioctl_addr[AW-1:0];
            pendData_d  = ioctl_dout;
        end

        if (state_q == ST_SAVE) ioctlDin_d = ram_dout;
    end

    // State and register update with synchronous active-low reset. Reset
    // returns ownership to the CPU at once, which aborts any transfer.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q     <= ST_CPU;
            dirty_q     <= 1'b0;
            armed_q     <= 1'b0;
            quietCnt_q  <= '0;
            saveReq_q   <= 1'b0;
            pendValid_q <= 1'b0;
            pendAddr_q  <= '0;
            pendData_q  <= '0;
            ioctlDin_q  <= '0;
        end else begin
            state_q     <= state_d;
            dirty_q     <= dirty_d;
            armed_q     <= armed_d;
            quietCnt_q  <= quietCnt_d;
            saveReq_q   <= saveReq_d;
            pendValid_q <= pendValid_d;
            pendAddr_q  <= pendAddr_d;
            pendData_q  <= pendData_d;
            ioctlDin_q  <= ioctlDin_d;
        end
    end

endmodule

// File: tb/tb_hiscore_arb.sv
// ---------------------------------------------------------------------------
// tb_hiscore_arb
//
// Testbench for hiscore_arb with a 100-cycle quiet time. It models the
// 64-byte synchronous RAM next to the DUT. A reference copy of the RAM
// contents, plus a countdown since the last CPU write, gives the expected
// values for reads, uploads and save requests.
// ---------------------------------------------------------------------------
module tb_hiscore_arb;

    localparam int          AW    = 6;
    localparam int          DW    = 8;
    localparam logic [7:0]  IDX   = 8'hFF;
    localparam logic [23:0] QUIET = 24'd100;

    logic          clk_sys;
    logic          reset_n;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_we;
    logic [DW-1:0] cpu_dout;
    logic          cpu_hold;
    logic          ioctl_download;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic [24:0]   ioctl_addr;
    logic          ioctl_wr;
    logic [7:0]    ioctl_dout;
    logic [DW-1:0] ioctl_din;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic          dirty;
    logic          save_req;

    logic [7:0] mem    [0:63];
    logic [7:0] refMem [0:63];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
        logic [7:0] expRead;
        logic       expDirty;
    } vec_t;

    vec_t vecs [4];

    hiscore_arb #(
        .AW(AW), .DW(DW), .IDX(IDX), .QUIET(QUIET)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .cpu_addr(cpu_addr),
        .cpu_din(cpu_din),
        .cpu_we(cpu_we),
        .cpu_dout(cpu_dout),
        .cpu_hold(cpu_hold),
        .ioctl_download(ioctl_download),
        .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr),
        .ioctl_wr(ioctl_wr),
        .ioctl_dout(ioctl_dout),
        .ioctl_din(ioctl_din),
        .ram_addr(ram_addr),
        .ram_din(ram_din),
        .ram_we(ram_we),
        .ram_dout(ram_dout),
        .dirty(dirty),
        .save_req(save_req)
    );

    // Free-running system clock.
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // The NVRAM itself: synchronous write and a registered read, one cycle latency.
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Stops a run that somehow stalls and still reports it.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic cpuWrite(input logic [5:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_din  = d;
        cpu_we   = 1'b1;
        tick();
        cpu_we   = 1'b0;
        refMem[a] = d;
    endtask

    task automatic cpuRead(input logic [5:0] a, output logic [7:0] d);
        cpu_addr = a;
        cpu_we   = 1'b0;
        tick();
        d = cpu_dout;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [7:0] rd;
        cpuWrite(v.addr, v.data);
        cpuRead(v.addr, rd);
        checkOutput("tbl_read", 32'(rd), 32'(v.expRead));
        checkOutput("tbl_dirty", 32'(dirty), 32'(v.expDirty));
    endtask

    task automatic readBackCheck(input string name, input int n);
        logic [7:0] rd;
        for (int i = 0; i < n; i++) begin
            cpuRead(6'(i), rd);
            checkOutput(name, 32'(rd), 32'(refMem[i]));
        end
    endtask

    // A write at tick 0, with an optional second write at tick secondAt.
    // Reports the number of cycles save_req was high and the tick of the first pulse.
    task automatic quietRun(input int secondAt, output int pulses, output int firstK);
        pulses = 0;
        firstK = -1;
        cpuWrite(6'd8, 8'h33);
        for (int k = 1; k <= 200; k++) begin
            if (k == secondAt) cpuWrite(6'd9, 8'h44);
            else tick();
            if (save_req === 1'b1) begin
                pulses++;
                if (firstK < 0) firstK = k;
            end
        end
    endtask

    task automatic download(input bit randomData);
        int holdBad;
        int gap;
        logic [7:0] d;
        logic [24:0] oorAddr [2];
        oorAddr[0] = 25'd69;
        oorAddr[1] = 25'h100_0005;
        holdBad = 0;
        ioctl_index    = IDX;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b1;
        tick();
        checkOutput("dl_hold_enter", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 64; i++) begin
            d = randomData ? 8'($urandom) : (8'h40 + 8'(i));
            ioctl_addr = 25'(i);
            ioctl_dout = d;
            ioctl_wr   = 1'b1;
            #1;
            if (i > 0) checkOutput("dl_ram_we", 32'(ram_we), 32'd1);
            tick();
            ioctl_wr  = 1'b0;
            refMem[i] = d;
            if (cpu_hold !== 1'b1) holdBad++;
            gap = randomData ? int'($urandom_range(1, 3)) : 1;
            for (int g = 0; g < gap; g++) begin
                tick();
                if (cpu_hold !== 1'b1) holdBad++;
            end
        end
        for (int j = 0; j < 2; j++) begin
            ioctl_addr = oorAddr[j];
            ioctl_dout = 8'hEE;
            ioctl_wr   = 1'b1;
            #1;
            checkOutput("dl_oor_we", 32'(ram_we), 32'd0);
            tick();
            ioctl_wr = 1'b0;
            tick();
            if (cpu_hold !== 1'b1) holdBad++;
        end
        ioctl_download = 1'b0;
        tick();
        tick();
        checkOutput("dl_hold_during", 32'(holdBad), 32'd0);
        checkOutput("dl_hold_release", 32'(cpu_hold), 32'd0);
        checkOutput("dl_dirty_clear", 32'(dirty), 32'd0);
    endtask

    task automatic uploadCheck();
        int weSeen;
        weSeen = 0;
        ioctl_index  = IDX;
        ioctl_addr   = 25'd0;
        ioctl_upload = 1'b1;
        tick();
        if (ram_we !== 1'b0) weSeen++;
        tick();
        for (int i = 0; i < 64; i++) begin
            ioctl_addr = 25'(i);
            if (ram_we !== 1'b0) weSeen++;
            tick();
            if (ram_we !== 1'b0) weSeen++;
            tick();
            checkOutput("ul_din", 32'(ioctl_din), 32'(refMem[i]));
        end
        ioctl_upload = 1'b0;
        tick();
        tick();
        checkOutput("ul_no_ram_we", 32'(weSeen), 32'd0);
        checkOutput("ul_hold_release", 32'(cpu_hold), 32'd0);
    endtask

    initial begin
        int pulses;
        int firstK;
        int holdSeen;
        int weSeen;
        int quietLeft;
        bit wrote;
        bit expPulse;
        int op;
        logic [5:0] a;
        logic [7:0] d;
        logic [7:0] rd;

        vecs[0] = '{6'd3,  8'h5A, 8'h5A, 1'b1};
        vecs[1] = '{6'd0,  8'h00, 8'h00, 1'b1};
        vecs[2] = '{6'd63, 8'hFF, 8'hFF, 1'b1};
        vecs[3] = '{6'd17, 8'hA5, 8'hA5, 1'b1};

        reset_n        = 1'b0;
        cpu_addr       = 6'd7;
        cpu_din        = 8'h11;
        cpu_we         = 1'b1;
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_addr     = 25'd0;
        ioctl_wr       = 1'b0;
        ioctl_dout     = 8'h00;

        $display("[TB] reset");
        tick();
        checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
        checkOutput("rst_hold", 32'(cpu_hold), 32'd0);
        checkOutput("rst_dirty", 32'(dirty), 32'd0);
        checkOutput("rst_save_req", 32'(save_req), 32'd0);
        checkOutput("rst_ioctl_din", 32'(ioctl_din), 32'd0);
        tick();
        reset_n = 1'b1;
        cpu_we  = 1'b0;
        tick();

        $display("[TB] table of CPU write/read vectors");
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);
        cpuRead(6'd3, rd);
        checkOutput("tbl_reread3", 32'(rd), 32'h5A);

        $display("[TB] quiet timer");
        quietRun(0, pulses, firstK);
        checkOutput("quiet_pulses", 32'(pulses), 32'd1);
        checkOutput("quiet_pulse_cycle", 32'(firstK), 32'(QUIET));
        quietRun(50, pulses, firstK);
        checkOutput("quiet2_pulses", 32'(pulses), 32'd1);
        checkOutput("quiet2_pulse_cycle", 32'(firstK), 32'(50 + int'(QUIET)));
        checkOutput("quiet_dirty_kept", 32'(dirty), 32'd1);

        $display("[TB] download on high-score index");
        checkOutput("pre_dl_dirty", 32'(dirty), 32'd1);
        download(1'b0);
        readBackCheck("dl_readback", 64);

        $display("[TB] upload on high-score index");
        uploadCheck();

        $display("[TB] download on foreign index");
        holdSeen = 0;
        weSeen   = 0;
        ioctl_index    = 8'h00;
        ioctl_download = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ioctl_addr = 25'(i);
            ioctl_dout = 8'hAA;
            ioctl_wr   = 1'b1;
            #1;
            if (ram_we !== 1'b0) weSeen++;
            tick();
            ioctl_wr = 1'b0;
            if (cpu_hold !== 1'b0) holdSeen++;
            tick();
            if (cpu_hold !== 1'b0) holdSeen++;
        end
        cpuWrite(6'd40, 8'h9C);
        ioctl_download = 1'b0;
        tick();
        checkOutput("idx0_hold", 32'(holdSeen), 32'd0);
        checkOutput("idx0_ram_we", 32'(weSeen), 32'd0);
        readBackCheck("idx0_readback", 8);
        cpuRead(6'd40, rd);
        checkOutput("idx0_cpu_write", 32'(rd), 32'h9C);

        $display("[TB] random CPU traffic with quiet-time model");
        cpuWrite(6'($urandom), 8'($urandom));
        quietLeft = int'(QUIET);
        for (int n = 0; n < 700; n++) begin
            op    = int'($urandom_range(0, 99));
            a     = 6'($urandom);
            d     = 8'($urandom);
            wrote = 1'b0;
            if (op < 4) begin
                cpuWrite(a, d);
                wrote = 1'b1;
            end else if (op < 30) begin
                cpuRead(a, rd);
                checkOutput("rnd_read", 32'(rd), 32'(refMem[a]));
            end else begin
                tick();
            end
            expPulse = 1'b0;
            if (wrote) begin
                quietLeft = int'(QUIET);
            end else if (quietLeft > 0) begin
                quietLeft--;
                expPulse = (quietLeft == 0);
            end
            checkOutput("rnd_save_req", 32'(save_req), 32'(expPulse));
        end

        $display("[TB] random download session and readback");
        download(1'b1);
        uploadCheck();
        readBackCheck("rnd_dl_readback", 64);

        $display("[TB] reset in the middle of a load");
        cpuWrite(6'd20, 8'h77);
        checkOutput("mid_pre_dirty", 32'(dirty), 32'd1);
        ioctl_index    = IDX;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            ioctl_addr = 25'(i);
            ioctl_dout = 8'h80 + 8'(i);
            ioctl_wr   = 1'b1;
            tick();
            ioctl_wr  = 1'b0;
            refMem[i] = 8'h80 + 8'(i);
            tick();
        end
        checkOutput("mid_hold_load", 32'(cpu_hold), 32'd1);
        ioctl_addr     = 25'd10;
        ioctl_dout     = 8'hC3;
        ioctl_wr       = 1'b1;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        #1;
        checkOutput("mid_rst_ram_we", 32'(ram_we), 32'd0);
        tick();
        checkOutput("mid_rst_hold", 32'(cpu_hold), 32'd0);
        checkOutput("mid_rst_dirty", 32'(dirty), 32'd0);
        checkOutput("mid_rst_save_req", 32'(save_req), 32'd0);
        ioctl_wr = 1'b0;
        reset_n  = 1'b1;
        tick();
        readBackCheck("mid_rst_readback", 11);
        readBackCheck("mid_rst_full", 64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hiscore_arb.md
# hiscore_arb

Arbiter and sequencer for the 64-byte high-score NVRAM shared between the game CPU and the data_io upload/download channel. It sits between the core's EAROM/hsram port, the CPU-side access bus and the ioctl bus. It grants ownership to ioctl transfers on the configured index, and stalls the CPU while a transfer runs. It also tracks unsaved CPU writes and raises a one-shot save request after CPU writes have been quiet for a programmable time.

## Interface
Parameters:
- AW, 6, RAM address width (64 entries)
- DW, 8, data width
- IDX, 8'hFF, ioctl_index value that selects the high-score channel
- QUIET, 24'd12_000_000, idle cycles after the last CPU write before save_req pulses (1 s at 12 MHz)

Ports:
- clk_sys  in  1  system clock (clk_12 domain)
- reset_n  in  1  synchronous, active-low reset
- cpu_addr  in  AW  CPU address
- cpu_din  in  DW  CPU write data
- cpu_we  in  1  CPU write strobe, one cycle per write
- cpu_dout  out  DW  CPU read data, registered
- cpu_hold  out  1  CPU stall; CPU must not strobe while high
- ioctl_download  in  1  data_io download active
- ioctl_upload  in  1  data_io upload active
- ioctl_index  in  8  data_io transfer index
- ioctl_addr  in  25  data_io byte address (low AW bits used)
- ioctl_wr  in  1  data_io write strobe
- ioctl_dout  in  8  data_io download byte
- ioctl_din  out  DW  upload byte to data_io
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_we  out  1  RAM write enable
- ram_dout  in  DW  RAM read data; synchronous, 1-cycle latency
- dirty  out  1  CPU has written since the last completed save or load
- save_req  out  1  one-cycle pulse requesting a save from the host

## Operation
- Session detection: sel = (ioctl_index == IDX). dl = ioctl_download & sel. ul = ioctl_upload & sel. dl and ul asserted together: dl wins.
- FSM states: CPU, HOLD, LOAD, SAVE, DONE.
  - CPU: CPU owns the RAM. ram_addr = cpu_addr, ram_din = cpu_din, ram_we = cpu_we. dl or ul → HOLD.
  - HOLD: cpu_hold = 1 for exactly one cycle so any in-flight CPU strobe drains. Then → LOAD if dl, → SAVE if ul, → CPU if neither is still active.
  - LOAD: ram_addr = ioctl_addr[AW-1:0], ram_din = ioctl_dout, ram_we = ioctl_wr & (ioctl_addr < 2**AW). Writes at addresses ≥ 64 are dropped. dl falling → DONE.
  - SAVE: ram_addr = ioctl_addr[AW-1:0], ram_we = 0, ioctl_din = ram_dout (registered). ul falling → DONE.
  - DONE: dirty ← 0, quiet counter cleared and disarmed, cpu_hold released. → CPU.
- cpu_hold is high in HOLD, LOAD and SAVE, and low otherwise. cpu_we asserted while cpu_hold is high is ignored and does not set dirty.
- ioctl_wr arriving during HOLD is captured in a one-entry pending register and written in the first LOAD cycle. A second write in the same window is not possible, because data_io strobes are at least 2 cycles apart.
- Dirty and quiet counter:
  - An accepted CPU write sets dirty, reloads the counter to QUIET and arms it.
  - While armed in CPU state, the counter decrements each cycle. On the transition to 0, save_req pulses and the counter disarms.
  - A new CPU write re-arms the counter.
  - Leaving CPU state freezes the counter. DONE disarms it.
- cpu_dout = ram_dout in all states. Data is only valid to the CPU in CPU state.

## Timing
- Reset (reset_n low at a clk_sys edge) forces:
  - state = CPU
  - cpu_hold = 0, dirty = 0, save_req = 0
  - ioctl_din = 0, counter disarmed, pending write cleared
  - ram_we = 0 for the reset cycle
- Reset during LOAD or SAVE aborts the transfer immediately. A partial load leaves the RAM contents as written.
- CPU read latency is 1 cycle: address at cycle n, cpu_dout valid at n+1.
- Upload latency: ioctl_addr changes at cycle n → ram_dout valid at n+1 → ioctl_din valid at n+2. data_io samples at least 2 cycles after an address change.
- HOLD to owner: the first ioctl RAM access happens 1 cycle after HOLD is entered.
- DONE lasts 1 cycle. The CPU regains access 2 cycles after dl or ul falls.
- A session with a non-matching ioctl_index (e.g. a ROM download on index 0) never leaves CPU state.

## Test plan
- CPU write 0x5A to address 3, then read address 3 → cpu_dout = 0x5A one cycle after the read address is applied; dirty = 1.
- Download on IDX of 64 bytes of value 0x40+addr, with dirty = 1 beforehand → cpu_hold high from the cycle after dl rises until 2 cycles after dl falls; RAM[i] = 0x40+i; dirty = 0.
- Upload on IDX after the above → ioctl_din = 0x40+addr, 2 cycles after each address change; no RAM writes occur.
- CPU write with QUIET = 100 → save_req is a single pulse 100 cycles later. A second write at cycle 50 delays the pulse to cycle 150.
- Download on index 0 and address-64 writes on IDX → no state change (index 0); the out-of-range writes produce no ram_we.
- reset_n low mid-LOAD at byte 10 → next cycle: state CPU, cpu_hold = 0, dirty = 0; bytes 0–9 are retained.
